// File: rtl/sap_cpu_core_p_if.sv
// Memory and OUT-port handshake bundle of the SAP-style accumulator core.
// The master is the CPU; the slave side is memory plus the OUT sink.
interface sap_cpu_core_p_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rd_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ready_i;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_ready_i;

    modport master (
        output mem_addr_o, mem_rd_o, mem_we_o, mem_data_o, out_valid_o, out_data_o,
        input  mem_data_i, mem_ready_i, out_ready_i
    );

    modport slave (
        input  mem_addr_o, mem_rd_o, mem_we_o, mem_data_o, out_valid_o, out_data_o,
        output mem_data_i, mem_ready_i, out_ready_i
    );
endinterface

// File: rtl/sap_cpu_core_p.sv
// Parametrised SAP-style accumulator CPU: T0..T4 fetch/execute sequencer with
// ready/valid memory and OUT ports, immediate ALU ops and registered flags.
module sap_cpu_core_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             reset_ni,
    input  logic             clk_en_i,
    sap_cpu_core_p_if.master bus,
    output logic             hlt_o,
    output logic             cf_o,
    output logic             zf_o
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_e;

    localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8;
    localparam logic [3:0] OP_ADI = 4'h9, OP_SUI = 4'hA, OP_OUT = 4'hE, OP_HLT = 4'hF;

    // Subtraction is A + ~B + 1, so the carry-out doubles as "no borrow".
    function automatic logic [DATA_W:0] alu(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic              sub);
        logic [DATA_W-1:0] bo;
        bo = sub ? ~b : b;
        return {1'b0, a} + {1'b0, bo} + {{DATA_W{1'b0}}, sub};
    endfunction

    step_e             step_q, step_d;
    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
    logic              outv_q, outv_d, hlt_q, hlt_d, cf_q, cf_d, zf_q, zf_d;

    logic [3:0]        op, fop;
    logic [ADDR_W-1:0] opnd;
    logic [DATA_W-1:0] opnd_x;
    logic [DATA_W:0]   sum;
    logic              rd, we;

    assign op     = ir_q[DATA_W-1 -: 4];
    assign fop    = bus.mem_data_i[DATA_W-1 -: 4];
    assign opnd   = ir_q[ADDR_W-1:0];
    assign opnd_x = DATA_W'(opnd);

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            step_q <= T0;
            pc_q   <= '0;
            mar_q  <= '0;
            ir_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            out_q  <= '0;
            outv_q <= 1'b0;
            hlt_q  <= 1'b0;
            cf_q   <= 1'b0;
            zf_q   <= 1'b0;
        end else if (clk_en_i) begin
            step_q <= step_d;
            pc_q   <= pc_d;
            mar_q  <= mar_d;
            ir_q   <= ir_d;
            a_q    <= a_d;
            b_q    <= b_d;
            out_q  <= out_d;
            outv_q <= outv_d;
            hlt_q  <= hlt_d;
            cf_q   <= cf_d;
            zf_q   <= zf_d;
        end
    end

    always_comb begin
        step_d = step_q;
        pc_d   = pc_q;
        mar_d  = mar_q;
        ir_d   = ir_q;
        a_d    = a_q;
        b_d    = b_q;
        out_d  = out_q;
        outv_d = outv_q;
        hlt_d  = hlt_q;
        cf_d   = cf_q;
        zf_d   = zf_q;
        sum    = '0;
        rd     = 1'b0;
        we     = 1'b0;

        case (step_q)
            T0: begin
                mar_d  = pc_q;
                step_d = T1;
            end
            T1: begin
                rd = 1'b1;
                if (bus.mem_ready_i) begin
                    ir_d   = bus.mem_data_i;
                    pc_d   = pc_q + ADDR_W'(1);
                    step_d = T2;
                    // OUT loads its register on fetch so data is valid with out_valid_o in T2.
                    if (fop == OP_OUT) begin
                        out_d  = a_q;
                        outv_d = 1'b1;
                    end
                end
            end
            T2: begin
                step_d = T0;
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        mar_d  = opnd;
                        step_d = T3;
                    end
                    OP_LDI: a_d = opnd_x;
                    OP_JMP: pc_d = opnd;
                    OP_JC:  if (cf_q) pc_d = opnd;
                    OP_JZ:  if (zf_q) pc_d = opnd;
                    OP_ADI, OP_SUI: begin
                        sum  = alu(a_q, opnd_x, op == OP_SUI);
                        a_d  = sum[DATA_W-1:0];
                        cf_d = sum[DATA_W];
                        zf_d = (sum[DATA_W-1:0] == '0);
                    end
                    OP_OUT: begin
                        if (bus.out_ready_i) outv_d = 1'b0;
                        else                 step_d = T2;
                    end
                    OP_HLT: begin
                        hlt_d  = 1'b1;
                        step_d = T2;
                    end
                    default: ;
                endcase
            end
            T3: begin
                if (op == OP_STA) begin
                    we = 1'b1;
                    if (bus.mem_ready_i) step_d = T0;
                end else begin
                    rd = 1'b1;
                    if (bus.mem_ready_i) begin
                        if (op == OP_LDA) begin
                            a_d    = bus.mem_data_i;
                            step_d = T0;
                        end else begin
                            b_d    = bus.mem_data_i;
                            step_d = T4;
                        end
                    end
                end
            end
            T4: begin
                sum    = alu(a_q, b_q, op == OP_SUB);
                a_d    = sum[DATA_W-1:0];
                cf_d   = sum[DATA_W];
                zf_d   = (sum[DATA_W-1:0] == '0);
                step_d = T0;
            end
            default: step_d = T0;
        endcase
    end

    assign bus.mem_addr_o  = mar_q;
    assign bus.mem_rd_o    = rd;
    assign bus.mem_we_o    = we;
    assign bus.mem_data_o  = we ? a_q : '0;
    assign bus.out_valid_o = outv_q;
    assign bus.out_data_o  = out_q;
    assign hlt_o           = hlt_q;
    assign cf_o            = cf_q;
    assign zf_o            = zf_q;

endmodule
